// File: rtl/audio_receiver.sv
// audio_receiver: I2S ADC capture, clocks from clk, 16-bit L/R samples.
// Ports: clk, rst (async low), audio_sdout in; mclk/sclk/lrclk, left/right/valid out.
module audio_receiver #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              audio_sdout,
  output logic              audio_mclk,
  output logic              audio_sclk,
  output logic              audio_lrclk,
  output logic [DATA_W-1:0] audio_left,
  output logic [DATA_W-1:0] audio_right,
  output logic              audio_valid
);

  localparam logic [9:0] CAP_L = 10'(DATA_W * 16 + 7);
  localparam logic [9:0] CAP_R = 10'(512 + DATA_W * 16 + 7);

  logic [9:0]        cnt;
  logic [4:0]        slot;
  logic              samp;
  logic              in_data;
  logic [DATA_W-2:0] sh;
  logic [DATA_W-1:0] sh_next;
  logic [DATA_W-1:0] left_hold;

  assign slot    = cnt[8:4];
  assign samp    = (cnt[3:0] == 4'd7);
  assign in_data = (slot >= 5'd1) && (slot <= 5'(DATA_W));

  assign audio_mclk  = cnt[1];
  assign audio_sclk  = cnt[3];
  assign audio_lrclk = cnt[9];

  // Slot 1 starts a fresh word so nothing leaks across channels.
  always_comb begin
    sh_next = {sh, audio_sdout};
    if (slot == 5'd1)
      sh_next = {{(DATA_W-1){1'b0}}, audio_sdout};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      sh          <= '0;
      left_hold   <= '0;
      audio_left  <= '0;
      audio_right <= '0;
      audio_valid <= 1'b0;
    end else begin
      cnt         <= cnt + 10'd1;
      audio_valid <= 1'b0;
      if (samp && in_data)
        sh <= sh_next[DATA_W-2:0];
      if (cnt == CAP_L)
        left_hold <= sh_next;
      // Left/right of one lrclk frame are published together.
      if (cnt == CAP_R) begin
        audio_right <= sh_next;
        audio_left  <= left_hold;
        audio_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_receiver.sv
// tb_audio_receiver: table/random frames into an I2S ADC model, outputs
// checked against per-frame expected words.
module tb_audio_receiver;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        fill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        audio_sdout = 1'b0;
  logic        audio_mclk, audio_sclk, audio_lrclk;
  logic [15:0] audio_left, audio_right;
  logic        audio_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_c;
  int clk_err;
  int first_sclk, first_lr;
  logic prev_sclk, prev_lr;

  logic [15:0] fl [16];
  logic [15:0] fr [16];
  logic        fill [16];
  logic [15:0] exp_l, exp_r;
  vec_t        tbl [5];

  audio_receiver #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .audio_sdout(audio_sdout),
    .audio_mclk(audio_mclk), .audio_sclk(audio_sclk),
    .audio_lrclk(audio_lrclk), .audio_left(audio_left),
    .audio_right(audio_right), .audio_valid(audio_valid)
  );

  always #5 clk = ~clk;

  // Edges since reset release: equals the design's counter phase.
  always @(posedge clk or negedge rst)
    if (!rst) tb_c <= 0;
    else      tb_c <= tb_c + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h",
               name, tb_c, act, req);
    end
  endtask

  // ADC model: bit on the line for the slot that the counter is in.
  function automatic logic bit_for(int c);
    int k, p, s;
    logic [15:0] w;
    k = c / 1024;
    p = c % 1024;
    s = (p / 16) % 32;
    if (k > 15) return 1'b0;
    w = (p >= 512) ? fr[k] : fl[k];
    if (s >= 1 && s <= 16) return w[16 - s];
    return fill[k];
  endfunction

  task automatic check_cycle();
    int p, k;
    logic ev;
    p  = tb_c % 1024;
    k  = tb_c / 1024;
    ev = (p == 776);
    if (ev) begin
      exp_l = fl[k];
      exp_r = fr[k];
    end
    if (ev || audio_valid) chk("valid", 32'(audio_valid), 32'(ev));
    if (ev || p == 775 || p == 1023) begin
      chk("left", 32'(audio_left), 32'(exp_l));
      chk("right", 32'(audio_right), 32'(exp_r));
    end
    if (audio_mclk  !== ((tb_c % 4) >= 2))     clk_err++;
    if (audio_sclk  !== ((tb_c % 16) >= 8))    clk_err++;
    if (audio_lrclk !== ((tb_c % 1024) >= 512)) clk_err++;
    if (!prev_sclk && audio_sclk && first_sclk < 0) first_sclk = tb_c;
    if (!prev_lr && audio_lrclk && first_lr < 0) first_lr = tb_c;
    prev_sclk = audio_sclk;
    prev_lr   = audio_lrclk;
  endtask

  task automatic run(int ncyc);
    clk_err = 0;
    audio_sdout = bit_for(tb_c);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      check_cycle();
      audio_sdout = bit_for(tb_c);
    end
    chk("clk_shape", 32'(clk_err), 32'd0);
  endtask

  task automatic do_reset(int ncyc);
    int bad;
    bad = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      audio_sdout = 1'($urandom);
      #1;
      if (audio_valid || audio_left != 0 || audio_right != 0 ||
          audio_mclk || audio_sclk || audio_lrclk)
        bad++;
    end
    chk("reset_outputs", 32'(bad), 32'd0);
    exp_l = '0;
    exp_r = '0;
    prev_sclk = 1'b0;
    prev_lr = 1'b0;
    first_sclk = -1;
    first_lr = -1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{16'hA5C3, 16'h3C5A, 1'b0};
    tbl[1] = '{16'h0001, 16'h8000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0};
    tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b1};

    // Reset with toggling data, then table frames as one stream.
    do_reset(50);
    for (int i = 0; i < 5; i++) begin
      fl[i] = tbl[i].l;
      fr[i] = tbl[i].r;
      fill[i] = tbl[i].fill;
    end
    run(5 * 1024);
    chk("sclk_first_rise", 32'(first_sclk), 32'd8);
    chk("lrclk_first_rise", 32'(first_lr), 32'd512);

    // Streaming: left = n, right = ~n.
    do_reset(5);
    for (int i = 0; i < 8; i++) begin
      fl[i] = 16'(i + 1);
      fr[i] = ~16'(i + 1);
      fill[i] = 1'b0;
    end
    run(8 * 1024);

    // Random words and random filler in ignored slots.
    do_reset(5);
    for (int i = 0; i < 6; i++) begin
      fl[i] = 16'($urandom);
      fr[i] = 16'($urandom);
      fill[i] = 1'($urandom);
    end
    run(6 * 1024);

    // Reset in the middle of the right channel.
    do_reset(5);
    fl[0] = 16'h1234;
    fr[0] = 16'h5678;
    fill[0] = 1'b1;
    run(600);
    rst = 1'b0;
    #1;
    chk("midreset_left", 32'(audio_left), 32'd0);
    chk("midreset_right", 32'(audio_right), 32'd0);
    chk("midreset_valid", 32'(audio_valid), 32'd0);
    repeat (10) @(posedge clk);
    exp_l = '0;
    exp_r = '0;
    fl[0] = 16'hBEEF;
    fr[0] = 16'hCAFE;
    fill[0] = 1'b1;
    fl[1] = 16'h0F0F;
    fr[1] = 16'hF0F0;
    fill[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(2 * 1024);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
